// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: widths, round count, S-box and rcon tables.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by the number of the round key being produced; entry 0 and 11..15 unused.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-expansion step: derives round key k from round key k-1 and its rcon byte.
module key_round_step
    import aes_pkg::*;
(
    input  logic [0:KEY_W-1] prev_key,
    input  logic [7:0]       rcon,
    output logic [0:KEY_W-1] next_key
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot_w, sub_w;
    logic [WORD_W-1:0] w4, w5, w6, w7;

    assign w0 = prev_key[0:31];
    assign w1 = prev_key[32:63];
    assign w2 = prev_key[64:95];
    assign w3 = prev_key[96:127];

    assign rot_w = {w3[23:0], w3[31:24]};

    assign sub_w[31:24] = sbox(rot_w[31:24]);
    assign sub_w[23:16] = sbox(rot_w[23:16]);
    assign sub_w[15:8]  = sbox(rot_w[15:8]);
    assign sub_w[7:0]   = sbox(rot_w[7:0]);

    assign w4 = w0 ^ sub_w ^ {rcon, 24'h000000};
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;

    assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per cycle into a store, served by index.
//   state     | meaning
//   ST_IDLE   | no valid keys, nkeys = 0
//   ST_EXPAND | rk[nkeys] computed this cycle from rk[nkeys-1]
//   ST_READY  | all NR+1 keys valid
module key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [0:KEY_W-1] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [0:KEY_W-1] rk_rd_data,
    output logic             rk_rd_valid,
    output logic             rk_rd_err,
    output logic             busy,
    output logic             keys_ready
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e        state_q, state_d;
    logic [3:0]       nkeys_q, nkeys_d;
    logic [0:KEY_W-1] rk [0:NR];

    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [0:KEY_W-1] wr_data;
    logic [0:KEY_W-1] prev_key;
    logic [0:KEY_W-1] step_key;
    logic             rd_hit;

    always_comb begin
        prev_key = '0;
        if (nkeys_q != 4'd0 && nkeys_q <= LAST_IDX + 4'd1) begin
            prev_key = rk[nkeys_q - 4'd1];
        end
    end

    key_round_step u_step (
        .prev_key (prev_key),
        .rcon     (RCON[nkeys_q]),
        .next_key (step_key)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            nkeys_q <= 4'd0;
        end else begin
            state_q <= state_d;
            nkeys_q <= nkeys_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nkeys_d = nkeys_q;
        wr_en   = 1'b0;
        wr_idx  = nkeys_q;
        wr_data = step_key;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_valid) begin
                    state_d = ST_EXPAND;
                    nkeys_d = 4'd1;
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_data = key_in;
                end
            end
            ST_EXPAND: begin
                wr_en   = 1'b1;
                nkeys_d = nkeys_q + 4'd1;
                if (nkeys_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                nkeys_d = 4'd0;
            end
        endcase
    end

    assign key_ready  = (state_q != ST_EXPAND);
    assign busy       = (state_q == ST_EXPAND);
    assign keys_ready = (state_q == ST_READY);

    // Store has no reset: nkeys alone decides which entries are readable.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            rk[wr_idx] <= wr_data;
        end
    end

    // Read sees the pre-write store and pre-update nkeys, so a key is never read in its write cycle.
    assign rd_hit = rk_rd_en && (rk_rd_idx < nkeys_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rk_rd_valid <= 1'b0;
            rk_rd_err   <= 1'b0;
            rk_rd_data  <= '0;
        end else begin
            rk_rd_valid <= rd_hit;
            rk_rd_err   <= rk_rd_en && !rd_hit;
            if (rd_hit) begin
                rk_rd_data <= rk[rk_rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: FIPS-197 vectors, streaming reads, bounds, rekey and reset.
module tb_key_sched_ctrl;

    logic         CLK;
    logic         RST;
    logic [0:127] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [0:127] rk_rd_data;
    logic         rk_rd_valid;
    logic         rk_rd_err;
    logic         busy;
    logic         keys_ready;

    key_sched_ctrl #(.NR(10)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid),
        .rk_rd_err   (rk_rd_err),
        .busy        (busy),
        .keys_ready  (keys_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         err;
        logic [0:127] data;
    } exp_t;

    exp_t         sb[$];
    logic         rd_pend;
    logic [0:127] exp_hold;
    int           checks;
    int           failures;
    logic [0:127] rk1 [0:10];
    logic [0:127] k2, k2_rk1, k2_rk10;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] idx, input logic err, input logic [0:127] data);
        exp_t e;
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        if (!err) exp_hold = data;
        e.err  = err;
        e.data = exp_hold;
        sb.push_back(e);
        rd_pend = 1'b1;
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge CLK);
        #1;
        rk_rd_en = 1'b0;
        if (rd_pend) begin
            rd_pend = 1'b0;
            e = sb.pop_front();
            chk("rd_valid", rk_rd_valid, !e.err);
            chk("rd_err", rk_rd_err, e.err);
            chk("rd_data", rk_rd_data, e.data);
        end else begin
            chk("rd_valid_quiet", rk_rd_valid, 1'b0);
            chk("rd_err_quiet", rk_rd_err, 1'b0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, key_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_keys_ready"}, keys_ready, 1'b0);
        chk({tag, "_rd_valid"}, rk_rd_valid, 1'b0);
        chk({tag, "_rd_err"}, rk_rd_err, 1'b0);
        chk({tag, "_rd_data"}, rk_rd_data, 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rd_pend  = 1'b0;
        exp_hold = '0;

        rk1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        k2      = 128'h000102030405060708090a0b0c0d0e0f;
        k2_rk1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        k2_rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        // Handshake offered during reset must be ignored.
        RST       = 1'b1;
        key_in    = rk1[0];
        key_valid = 1'b1;
        rk_rd_en  = 1'b0;
        rk_rd_idx = 4'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST       = 1'b0;
        key_valid = 1'b0;
        chk_reset_outputs("reset");

        rd(4'd0, 1'b1, '0); cyc();
        rd(4'd5, 1'b1, '0); cyc();
        chk("idle_key_ready", key_ready, 1'b1);

        // FIPS key accepted in cycle 0, key_valid held through expansion, streaming reads.
        key_in    = rk1[0];
        key_valid = 1'b1;
        cyc();
        for (int c = 1; c <= 10; c++) begin
            chk("exp_busy", busy, 1'b1);
            chk("exp_key_ready", key_ready, 1'b0);
            chk("exp_keys_ready", keys_ready, 1'b0);
            rd(4'(c - 1), 1'b0, rk1[c - 1]);
            if (c == 10) key_valid = 1'b0;
            cyc();
        end
        chk("c11_keys_ready", keys_ready, 1'b1);
        chk("c11_busy", busy, 1'b0);
        chk("c11_key_ready", key_ready, 1'b1);

        rd(4'd11, 1'b1, '0);      cyc();
        rd(4'd15, 1'b1, '0);      cyc();
        rd(4'd10, 1'b0, rk1[10]); cyc();
        rd(4'd1,  1'b0, rk1[1]);  cyc();

        // Rekey in READY with a simultaneous read of idx 0 returning the old key.
        key_in    = k2;
        key_valid = 1'b1;
        rd(4'd0, 1'b0, rk1[0]);
        cyc();
        key_valid = 1'b0;
        chk("rekey_keys_ready_drop", keys_ready, 1'b0);
        chk("rekey_busy", busy, 1'b1);
        rd(4'd0, 1'b0, k2);     cyc();
        rd(4'd1, 1'b0, k2_rk1); cyc();
        rd(4'd3, 1'b1, '0);     cyc();
        repeat (6) cyc();
        chk("rekey_c10_keys_ready", keys_ready, 1'b0);
        cyc();
        chk("rekey_c11_keys_ready", keys_ready, 1'b1);
        rd(4'd10, 1'b0, k2_rk10); cyc();

        // Reset in cycle 5 of an expansion.
        key_in    = rk1[0];
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        repeat (4) cyc();
        chk("mid_busy", busy, 1'b1);
        RST = 1'b1;
        cyc();
        RST      = 1'b0;
        exp_hold = '0;
        chk_reset_outputs("midrst");
        rd(4'd2, 1'b1, '0); cyc();

        key_in    = k2;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        n = 1;
        while (!keys_ready && n < 20) begin
            cyc();
            n++;
        end
        chk("fresh_ready_latency", 32'(n), 32'd11);
        rd(4'd10, 1'b0, k2_rk10); cyc();
        rd(4'd0,  1'b0, k2);      cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Iterative AES-128 key-schedule controller. It accepts a cipher key through a valid/ready handshake and computes one 128-bit round key per cycle into an 11-entry round-key store. It then serves round keys by index to the cipher round datapath. Reads of any key already computed are allowed during expansion, so the cipher can start round 0 before the schedule completes.

## Interface
Parameters:
- NR, 10, number of AES rounds; the store holds NR+1 keys.

Ports:
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset, synchronous and active-high.
- key_in  in  [0:127]  cipher key; word0 = key_in[0:31], MSB-first byte order.
- key_valid  in  1  key offer.
- key_ready  out  1  block accepts a key.
- rk_rd_en  in  1  round-key read request.
- rk_rd_idx  in  4  round-key index, 0..NR.
- rk_rd_data  out  [0:127]  registered read data.
- rk_rd_valid  out  1  read-data valid pulse.
- rk_rd_err  out  1  read rejected pulse.
- busy  out  1  expansion in progress.
- keys_ready  out  1  all NR+1 keys valid.

## Operation
- States:
  - IDLE: no valid keys.
  - EXPAND: computing keys.
  - READY: all keys valid.
- nkeys counter, 0..NR+1, holds the number of valid stored keys. IDLE implies nkeys=0.
- Accept: key_valid && key_ready. Then rk[0] <= key_in, nkeys <= 1, state <= EXPAND.
- EXPAND, every cycle:
  - rk[nkeys] <= step(rk[nkeys-1], rcon(nkeys)); nkeys <= nkeys+1.
  - When nkeys+1 == NR+1, state <= READY.
- step(): w4 = w0 ^ SubWord(RotWord(w3)) ^ rcon; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
- rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
- key_ready = (state != EXPAND). In EXPAND a new key is not accepted and key_valid is ignored.
- Rekey in READY: accept behaves as from IDLE. keys_ready drops the next cycle and old keys become invalid.
- Read when rk_rd_en=1:
  - If rk_rd_idx < nkeys (value in the request cycle): rk_rd_valid=1 and rk_rd_data=rk[idx] next cycle.
  - Otherwise (including idx > NR, IDLE, or a key not yet computed): rk_rd_err=1 next cycle, rk_rd_valid=0, rk_rd_data holds its previous value.
- Simultaneous read and key accept: the read is evaluated against pre-accept nkeys and pre-accept store contents.
- Simultaneous read of rk[n] in the cycle rk[n] is being written: rejected, because idx == nkeys.
- RST mid-EXPAND: returns to IDLE, nkeys=0, the store contents are don't-care, and no partial keys are readable.

## Timing
- Reset values:
  - State IDLE, nkeys 0.
  - key_ready 1.
  - busy 0, keys_ready 0, rk_rd_valid 0, rk_rd_err 0, rk_rd_data 0.
- Handshakes seen while RST=1 are ignored.
- Accept in cycle 0: busy=1 in cycles 1..10, keys_ready=1 from cycle 11, key_ready=0 in cycles 1..10.
- rk[k] is readable by a request in cycle ≥ k+1, with data in the following cycle.
- Read latency is 1 cycle, full throughput (one read per cycle), in any state.
- busy, keys_ready and key_ready are decoded from registered state, so they have no combinational path from inputs.

## Structure
- Package aes_pkg holds:
  - The sbox function and the rcon table.
  - The state enum.
  - NR and the key/word width constants.
- Sub-module key_round_step: purely combinational, with inputs prev_key [0:127] and rcon [7:0], output next_key [0:127]. It contains 4 S-box instances.
- This block holds the state FSM, nkeys, the 11x128 store and the read port.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, accepted at cycle 0:
  - keys_ready rises at cycle 11.
  - Reading idx 1 gives a0fafe1788542cb123a339392a6c7605.
  - Reading idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Streaming reads during EXPAND: request idx 0 in cycle 1, idx 1 in cycle 2, and so on.
  - Every read is valid.
  - Requesting idx 3 in cycle 3 gives rk_rd_err=1.
- Reset and bounds:
  - Reads in IDLE after reset give err.
  - In READY, idx 11 and idx 15 give err; idx 10 gives valid.
- key_valid held during EXPAND: key_ready stays 0 and no re-accept occurs.
  - In READY, key 000102030405060708090a0b0c0d0e0f is accepted.
  - keys_ready drops, then rises 11 cycles later.
  - rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Read idx 0 in the same cycle a rekey is accepted: the old rk[0] is returned. Reading idx 0 the next cycle returns the new key.
- RST asserted in cycle 5 of EXPAND:
  - All outputs return to their reset values next cycle.
  - A read of idx 2 then gives err.
  - A fresh key completes normally.
